sub_shift_stage: RTL and testbench
==================================

SUB_SHIFT_STAGE -- requirements
Module: sub_shift_stage

Interface
REQ-001 SHALL have parameter: LANES, 4, S-box instances per cycle; legal values 4 (column-serial) or 16 (single-pass); any other value is a synthesis error.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  data_in carries a valid AES state.
REQ-005 SHALL have port: in_ready  output  1  stage accepts data_in this cycle.
REQ-006 SHALL have port: data_in  input  128  state; byte i = data_in[127-8i -: 8]; column c = bytes 4c..4c+3, row r = byte index mod 4.
REQ-007 SHALL have port: out_valid  output  1  data_out holds a completed SubBytes+ShiftRows result.
REQ-008 SHALL have port: out_ready  input  1  downstream (MixColumns stage) takes data_out this cycle.
REQ-009 SHALL have port: data_out  output  128  result, same byte/column ordering as data_in.
REQ-010 SHALL have port: busy  output  1  high in SUB and HOLD states.

Function
REQ-011 SHALL implement S-box as a combinational 256-entry FIPS-197 forward lookup, LANES instances.
REQ-012 SHALL implement FSM states IDLE, SUB, HOLD.
REQ-013 IDLE: in_ready=1; on in_valid, capture data_in into state register, column counter cnt=0, go SUB.
REQ-014 SUB, LANES=4: each cycle replace column cnt of state register with S-box(each byte); cnt increments; at cnt==3 go HOLD.
REQ-015 SUB, LANES=16: all 16 bytes substituted in one cycle, then go HOLD.
REQ-016 On SUB->HOLD edge, data_out SHALL be registered with ShiftRows(fully substituted state): out byte r+4c = substituted byte r+4((c+r) mod 4).
REQ-017 HOLD: out_valid=1; data_out SHALL remain stable until the handshake out_valid&out_ready.
REQ-018 in_ready SHALL equal (state==IDLE) | (state==HOLD & out_ready).
REQ-019 HOLD with out_ready=1 and in_valid=1: complete output transfer and capture new data_in in same edge, go SUB (back-to-back).
REQ-020 HOLD with out_ready=1 and in_valid=0: go IDLE; out_valid low next cycle.
REQ-021 Latency: out_valid asserted 4 edges after accept edge (LANES=4), 1 edge (LANES=16); throughput one block per 5 cycles (LANES=4) / 2 cycles (LANES=16) with out_ready held high.
REQ-022 in_valid while in SUB SHALL be ignored (in_ready=0); data_in not sampled.
REQ-023 out_ready while not in HOLD SHALL have no effect.
REQ-024 cnt SHALL be 2 bits and never wrap while in SUB beyond 3.
REQ-025 data_out SHALL be purely registered; no combinational path from data_in or out_ready to data_out.

Reset
REQ-026 rst=1 SHALL force state=IDLE, cnt=0, out_valid=0, busy=0, data_out=128'h0, state register=0 on the next edge, regardless of state.
REQ-027 in_ready SHALL be 1 in the cycle after reset release.
REQ-028 Reset asserted during SUB or HOLD SHALL discard the in-flight block; no out_valid pulse for it after release.
REQ-029 rst SHALL take priority over simultaneous in_valid/out_ready handshakes.

Verification
REQ-030 FIPS-197 App. B round 1: data_in=193de3bea0f4e22b9ac68d2ae9f84808 -> data_out=d4bf5d30e0b452aeb84111f11e2798e5, out_valid 4 edges after accept (LANES=4).
REQ-031 data_in=all zero -> data_out=all 63 bytes (636363...63); same for LANES=16 with 1-edge latency.
REQ-032 out_ready held 0 for 10 cycles in HOLD -> data_out stable, in_ready=0, out_valid=1 throughout; on out_ready=1 single transfer.
REQ-033 Two blocks with in_valid and out_ready held 1 -> second accepted on first's output edge; outputs 5 cycles apart, no loss or duplication.
REQ-034 rst pulsed at cnt==2 -> out_valid stays 0, data_out=0, in_ready=1 next cycle; following block processed correctly.
REQ-035 Random 1000 blocks with random out_ready/in_valid stalls -> output stream matches software SubBytes+ShiftRows model, in order.

Source files
------------

// File: rtl/sub_shift_stage.sv
// AES SubBytes + ShiftRows pipeline stage.
// The 128-bit state is loaded into a working register. It is substituted either
// one column per cycle (LANES=4) or all at once (LANES=16). The ShiftRows
// result is registered into data_out, which is held until the downstream
// stage takes it.

// One forward AES S-box lane. Purely combinational table lookup.
module sub_shift_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX[i_byte];
endmodule

module sub_shift_stage #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    typedef enum logic [1:0] {S_IDLE, S_SUB, S_HOLD} state_t;

    state_t       r_fsm;
    logic [127:0] r_state;
    logic [1:0]   r_cnt;
    logic         r_out_valid;
    logic         r_busy;
    logic [127:0] r_data_out;

    // Views of the state as [column][row][bit]; byte r+4c lives at [3-c][3-r].
    logic [3:0][3:0][7:0]   w_st;
    logic [3:0][3:0][7:0]   w_full;
    logic [3:0][3:0][7:0]   w_shift;
    logic [LANES-1:0][7:0]  w_lane_in;
    logic [LANES-1:0][7:0]  w_lane_out;
    logic                   w_last;

    assign w_st = r_state;

    generate
        if (LANES == 4) begin : g_col
            // Column-serial: the lanes work on column r_cnt. The result is the
            // state with that column replaced, so on the last pass it is the
            // fully substituted block.
            logic [3:0][7:0] w_newcol;
            for (genvar j = 0; j < 4; j++) begin : g_lane
                assign w_lane_in[j]    = w_st[~r_cnt][3-j];
                assign w_newcol[3-j]   = w_lane_out[j];
            end
            // Splice the freshly substituted column into the working state
            always_comb begin
                w_full         = w_st;
                w_full[~r_cnt] = w_newcol;
            end
            assign w_last = (r_cnt == 2'd3);
        end else if (LANES == 16) begin : g_all
            // Single-pass: every byte has its own lane
            for (genvar j = 0; j < 16; j++) begin : g_lane
                assign w_lane_in[j]             = w_st[3-j/4][3-j%4];
                assign w_full[3-j/4][3-j%4]     = w_lane_out[j];
            end
            assign w_last = 1'b1;
        end else begin : g_bad
            $error("sub_shift_stage: LANES must be 4 or 16");
        end
    endgenerate

    for (genvar l = 0; l < LANES; l++) begin : g_sbox
        sub_shift_sbox u_sbox (
            .i_byte(w_lane_in[l]),
            .o_byte(w_lane_out[l])
        );
    end

    // ShiftRows: row r rotates left by r columns
    for (genvar c = 0; c < 4; c++) begin : g_sr_col
        for (genvar r = 0; r < 4; r++) begin : g_sr_row
            assign w_shift[3-c][3-r] = w_full[3-((c+r)%4)][3-r];
        end
    end

    assign in_ready  = (r_fsm == S_IDLE) | ((r_fsm == S_HOLD) & out_ready);
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign busy      = r_busy;

    // Control FSM with the working state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_cnt       <= '0;
            r_state     <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= data_in;
                        r_cnt   <= '0;
                        r_fsm   <= S_SUB;
                        r_busy  <= 1'b1;
                    end
                end
                S_SUB: begin
                    r_state <= w_full;
                    if (w_last) begin
                        r_fsm       <= S_HOLD;
                        r_data_out  <= w_shift;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            // Back-to-back: hand off and reload on the same edge
                            r_state <= data_in;
                            r_cnt   <= '0;
                            r_fsm   <= S_SUB;
                        end else begin
                            r_fsm  <= S_IDLE;
                            r_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_fsm       <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sub_shift_stage.sv
// Self-checking bench for sub_shift_stage. It runs LANES=4 and LANES=16
// instances side by side. The reference S-box is derived from the GF(2^8)
// inverse plus the affine map.
module tb_sub_shift_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         iv[2];
    logic [127:0] di[2];
    logic         ordy[2];
    logic         irdy[2];
    logic         ov[2];
    logic         bsy[2];
    logic [127:0] dout[2];

    sub_shift_stage #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .data_in(di[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .data_out(dout[0]), .busy(bsy[0])
    );
    sub_shift_stage #(.LANES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .data_in(di[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .data_out(dout[1]), .busy(bsy[1])
    );

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] sb[256];

    typedef struct {
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] t;
        for (int x = 0; x < 256; x++) begin
            t = 8'h00;
            if (x != 0) begin
                t = 8'h01;
                for (int k = 0; k < 254; k++) t = gmul(t, 8'(x));
            end
            sb[x] = t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
        end
    endtask

    // SubBytes then ShiftRows: out byte r+4c = S(in byte r+4((c+r) mod 4))
    function automatic logic [127:0] ref_model(input logic [127:0] d);
        logic [7:0]   s[16];
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) s[i] = sb[d[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[r + 4*((c+r)%4)];
        return o;
    endfunction

    // Offer one block to an idle DUT and count edges until out_valid
    task automatic send_and_wait(input int sel, input logic [127:0] d,
                                 output int lat, output logic [127:0] got);
        iv[sel] = 1'b1; di[sel] = d; ordy[sel] = 1'b0;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        lat = 0;
        while (!ov[sel] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = dout[sel];
    endtask

    task automatic release_out(input int sel, input string name);
        ordy[sel] = 1'b1;
        @(posedge clk); #1;
        ordy[sel] = 1'b0;
        chk(name, 128'(ov[sel]), 128'(0));
    endtask

    // Two blocks with in_valid and out_ready held high
    task automatic b2b(input int sel, input int period);
        logic [127:0] blk[2];
        logic [127:0] rxd[2];
        int acc_cyc[2], xfr_cyc[2];
        int idx, rx, extra;
        logic a, x;
        blk[0] = vt[0].din; blk[1] = vt[3].din;
        rxd[0] = '0; rxd[1] = '0;
        acc_cyc[0] = -1; acc_cyc[1] = -1; xfr_cyc[0] = -1; xfr_cyc[1] = -1;
        idx = 0; rx = 0; extra = 0;
        ordy[sel] = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            iv[sel] = (idx < 2);
            di[sel] = blk[idx < 2 ? idx : 1];
            #1;
            a = iv[sel] && irdy[sel];
            x = ov[sel] && ordy[sel];
            if (x) begin
                if (rx < 2) begin
                    rxd[rx] = dout[sel]; xfr_cyc[rx] = cyc; rx++;
                end else extra++;
            end
            @(posedge clk); #1;
            if (a) begin
                acc_cyc[idx] = cyc; idx++;
            end
        end
        iv[sel] = 1'b0; ordy[sel] = 1'b0;
        chk("b2b_count", 128'(rx), 128'(2));
        chk("b2b_extra", 128'(extra), 128'(0));
        chk("b2b_data0", rxd[0], vt[0].dexp);
        chk("b2b_data1", rxd[1], vt[3].dexp);
        chk("b2b_period", 128'(xfr_cyc[1] - xfr_cyc[0]), 128'(period));
        chk("b2b_accept_on_xfer", 128'(acc_cyc[1]), 128'(xfr_cyc[0]));
    endtask

    // Random traffic with stalls on both sides, scored against ref_model
    task automatic rand_run(input int sel, input int nblk);
        logic [127:0] q[$];
        logic [127:0] e;
        int sent, cyc;
        logic a, x;
        sent = 0; cyc = 0;
        while ((sent < nblk || q.size() > 0) && cyc < 20*nblk + 100) begin
            iv[sel]   = (sent < nblk) && ($urandom_range(0, 3) != 0);
            di[sel]   = {$urandom, $urandom, $urandom, $urandom};
            ordy[sel] = (sent >= nblk) || ($urandom_range(0, 2) != 0);
            #1;
            a = iv[sel] && irdy[sel];
            x = ov[sel] && ordy[sel];
            if (x) begin
                if (q.size() == 0) chk("rand_unexpected_out", 128'(1), 128'(0));
                else begin
                    e = q.pop_front();
                    chk("rand_data", dout[sel], e);
                end
            end
            @(posedge clk); #1;
            if (a) begin
                q.push_back(ref_model(di[sel]));
                sent++;
            end
            cyc++;
        end
        iv[sel] = 1'b0; ordy[sel] = 1'b0;
        chk("rand_sent", 128'(sent), 128'(nblk));
        chk("rand_drained", 128'(q.size()), 128'(0));
        @(posedge clk); #1;
        chk("rand_idle_after", 128'(ov[sel]), 128'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [127:0] got;
        logic bad;

        vt[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        vt[1] = '{128'h0, {16{8'h63}}};
        vt[2] = '{{16{8'hff}}, {16{8'h16}}};
        vt[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h636b6776f201ab7b30d777c5fe7c6f2b};

        build_sbox();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; di[s] = '0; ordy[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset_out_valid", 128'(ov[s]), 128'(0));
            chk("reset_busy", 128'(bsy[s]), 128'(0));
            chk("reset_data_out", dout[s], 128'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_reset4", 128'(irdy[0]), 128'(1));
        chk("in_ready_after_reset16", 128'(irdy[1]), 128'(1));

        // Known-answer table on both lane widths
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 2; s++) begin
                send_and_wait(s, vt[i].din, lat, got);
                chk(s == 0 ? "latency4" : "latency16", 128'(lat), 128'(s == 0 ? 4 : 1));
                chk(s == 0 ? "kat4" : "kat16", got, vt[i].dexp);
                chk("busy_in_hold", 128'(bsy[s]), 128'(1));
                release_out(s, "release_valid_low");
                chk("busy_after_release", 128'(bsy[s]), 128'(0));
            end
        end

        // Downstream stall: output held for 10 cycles, then exactly one transfer
        send_and_wait(0, vt[0].din, lat, got);
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ov[0] !== 1'b1 || irdy[0] !== 1'b0 || dout[0] !== vt[0].dexp) bad = 1'b1;
        end
        chk("stall_stable", 128'(bad), 128'(0));
        ordy[0] = 1'b1; #1;
        chk("stall_in_ready_on_ready", 128'(irdy[0]), 128'(1));
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("stall_single_xfer", 128'(ov[0]), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("stall_no_repeat", 128'(ov[0]), 128'(0));

        b2b(0, 5);
        b2b(1, 2);

        // Reset in the middle of column-serial substitution (cnt == 2)
        iv[0] = 1'b1; di[0] = vt[1].din;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_out_valid", 128'(ov[0]), 128'(0));
        chk("midreset_data_out", dout[0], 128'(0));
        chk("midreset_in_ready", 128'(irdy[0]), 128'(1));
        chk("midreset_busy", 128'(bsy[0]), 128'(0));
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ov[0] !== 1'b0) bad = 1'b1;
        end
        chk("midreset_no_pulse", 128'(bad), 128'(0));
        send_and_wait(0, vt[2].din, lat, got);
        chk("postreset_latency", 128'(lat), 128'(4));
        chk("postreset_data", got, vt[2].dexp);
        release_out(0, "postreset_release");

        // Reset wins over a simultaneous output+input handshake in HOLD
        send_and_wait(0, vt[0].din, lat, got);
        ordy[0] = 1'b1; iv[0] = 1'b1; di[0] = vt[3].din; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b0;
        chk("rstprio_out_valid", 128'(ov[0]), 128'(0));
        chk("rstprio_busy", 128'(bsy[0]), 128'(0));
        chk("rstprio_data_out", dout[0], 128'(0));
        repeat (5) @(posedge clk);
        #1;
        chk("rstprio_nothing_captured", 128'(ov[0]), 128'(0));

        rand_run(0, 1000);
        rand_run(1, 300);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
